// File: rtl/risc_v_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_mc_control
// Description : Multicycle RISC-V control unit. A Moore FSM sequences a shared
//               instruction/data memory and one ALU over several cycles per
//               instruction, with MemReady stretching the memory states.
//               Unsupported instructions are trapped, and retired
//               instructions are counted.
// Ports       : CLK, RST (async, active-high)
//               op, funct3, funct7_5 : fields of the instruction register
//               Zero                 : ALU zero flag (branch resolution)
//               MemReady             : memory access completes this cycle
//               PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//               ALUSrcB, ALUControl, ImmSrc, RegWrite : datapath controls
//               Illegal              : unsupported instruction trapped
//               InstrRetired         : retired-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_mc_control #(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int IMM_SRC_WIDTH  = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic                      funct7_5,
    input  logic                      Zero,
    input  logic                      MemReady,
    output logic                      PCWrite,
    output logic                      AdrSrc,
    output logic                      MemWrite,
    output logic                      IRWrite,
    output logic [1:0]                ResultSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
    output logic                      RegWrite,
    output logic                      Illegal,
    output logic [CNT_WIDTH-1:0]      InstrRetired
);

    localparam logic [OP_WIDTH-1:0] OP_LW     = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_SW     = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_IALU   = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);

    localparam logic [FUNCT3_WIDTH-1:0] F3_000 = FUNCT3_WIDTH'(3'b000);
    localparam logic [FUNCT3_WIDTH-1:0] F3_001 = FUNCT3_WIDTH'(3'b001);
    localparam logic [FUNCT3_WIDTH-1:0] F3_010 = FUNCT3_WIDTH'(3'b010);
    localparam logic [FUNCT3_WIDTH-1:0] F3_110 = FUNCT3_WIDTH'(3'b110);
    localparam logic [FUNCT3_WIDTH-1:0] F3_111 = FUNCT3_WIDTH'(3'b111);

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b011);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b101);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   retired_q;

    logic                   alu_f3_ok;
    logic                   retire;
    logic [1:0]             alu_op;
    logic                   pcw;
    logic                   irw;
    logic                   memw;
    logic                   regw;

    // R-type and I-ALU share the supported funct3 set
    assign alu_f3_ok = (funct3 == F3_000) || (funct3 == F3_010) ||
                       (funct3 == F3_110) || (funct3 == F3_111);

    // A store retires only on the cycle its write is accepted
    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEMWRITE) && MemReady);

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW:     state_d = (funct3 == F3_010) ? S_MEMADR : S_TRAP;
                    OP_SW:     state_d = (funct3 == F3_010) ? S_MEMADR : S_TRAP;
                    OP_RTYPE:  state_d = alu_f3_ok ? S_EXECR : S_TRAP;
                    OP_IALU:   state_d = alu_f3_ok ? S_EXECI : S_TRAP;
                    OP_JAL:    state_d = S_JAL;
                    OP_BRANCH: state_d = ((funct3 == F3_000) || (funct3 == F3_001))
                                         ? S_BRANCH : S_TRAP;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;   // unused encodings recover
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        pcw       = 1'b0;
        irw       = 1'b0;
        memw      = 1'b0;
        regw      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        Illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = MemReady;
                pcw       = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                regw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                // funct3[0] selects bne, which inverts the taken condition
                pcw     = Zero ^ funct3[0];
            end
            S_TRAP: begin
                Illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ALU decoder
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            2'b01:   ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    // op[5] separates R-type sub from I-ALU addi
                    F3_000:  ALUControl = (funct7_5 & op[5]) ? ALU_SUB : ALU_ADD;
                    F3_010:  ALUControl = ALU_SLT;
                    F3_110:  ALUControl = ALU_OR;
                    F3_111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        case (op)
            OP_SW:     ImmSrc = IMM_SRC_WIDTH'(2'b01);
            OP_BRANCH: ImmSrc = IMM_SRC_WIDTH'(2'b10);
            OP_JAL:    ImmSrc = IMM_SRC_WIDTH'(2'b11);
            default:   ImmSrc = IMM_SRC_WIDTH'(2'b00);
        endcase
    end

    // Architectural write enables are held off for the whole reset window
    assign PCWrite      = pcw  & ~RST;
    assign IRWrite      = irw  & ~RST;
    assign MemWrite     = memw & ~RST;
    assign RegWrite     = regw & ~RST;
    assign InstrRetired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_v_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_v_mc_control
// Description : Directed, self-checking bench for risc_v_mc_control. A second
//               instance with a 2-bit counter runs the same stimulus to
//               exercise counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_v_mc_control;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       MemReady;

    logic        pcw1, adr1, mw1, irw1, rw1, ill1;
    logic [1:0]  rs1, sa1, sb1, imm1;
    logic [2:0]  alu1;
    logic [31:0] cnt1;

    logic        pcw2, adr2, mw2, irw2, rw2, ill2;
    logic [1:0]  rs2, sa2, sb2, imm2;
    logic [2:0]  alu2;
    logic [1:0]  cnt2;

    risc_v_mc_control dut (
        .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
        .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1),
        .ImmSrc(imm1), .RegWrite(rw1), .Illegal(ill1), .InstrRetired(cnt1)
    );

    risc_v_mc_control #(.CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2),
        .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUControl(alu2),
        .ImmSrc(imm2), .RegWrite(rw2), .Illegal(ill2), .InstrRetired(cnt2)
    );

    always #5 CLK = ~CLK;

    wire [16:0] obs1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, alu1, imm1, rw1, ill1};
    wire [16:0] obs2 = {pcw2, adr2, mw2, irw2, rs2, sa2, sb2, alu2, imm2, rw2, ill2};

    typedef struct {
        string       tag;
        logic [16:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt;

    // Pack of the control outputs in port order
    function automatic logic [16:0] v(input logic pcw, input logic adr,
                                      input logic mw, input logic irw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sbv, input logic [2:0] alu,
                                      input logic [1:0] imm, input logic rw,
                                      input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sbv, alu, imm, rw, ill};
    endfunction

    function automatic logic [16:0] v_fetch(input logic [1:0] imm, input logic mr);
        return v(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [16:0] v_decode(input logic [1:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [16:0] v_aluwb(input logic [1:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b0);
    endfunction

    function automatic logic [16:0] v_rst(input logic [1:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
    endfunction

    task automatic push_exp(input string tag, input logic [16:0] ctl);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        assert (obs1 === e.ctl) else begin
            n_err++;
            $error("FAIL %s ctl: got %b expected %b", e.tag, obs1, e.ctl);
        end
        n_vec++;
        assert (cnt1 === e.cnt) else begin
            n_err++;
            $error("FAIL %s cnt: got %0d expected %0d", e.tag, cnt1, e.cnt);
        end
        n_vec++;
        assert (obs2 === e.ctl) else begin
            n_err++;
            $error("FAIL %s ctl2: got %b expected %b", e.tag, obs2, e.ctl);
        end
        n_vec++;
        assert (cnt2 === e.cnt[1:0]) else begin
            n_err++;
            $error("FAIL %s cnt2: got %0d expected %0d", e.tag, cnt2, e.cnt[1:0]);
        end
    endtask

    // One clock cycle: check at the falling edge, then advance past the rising edge
    task automatic step(input string tag, input logic [16:0] ctl);
        push_exp(tag, ctl);
        @(negedge CLK);
        check_now();
        @(posedge CLK);
        #1;
    endtask

    // Check between clock edges (used right after an asynchronous reset)
    task automatic check_async(input string tag, input logic [16:0] ctl);
        push_exp(tag, ctl);
        #1;
        check_now();
    endtask

    initial begin
        RST = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        Zero = 1'b0; MemReady = 1'b1; exp_cnt = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        step("reset", v_rst(2'b00));
        RST = 1'b0;

        // R-type sub
        step("r_fetch", v_fetch(2'b00, 1'b1));
        step("r_decode", v_decode(2'b00));
        step("r_execr", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0));
        step("r_aluwb", v_aluwb(2'b00));
        exp_cnt++;

        // lw with three wait cycles in MEMREAD
        op = 7'b0000011; funct3 = 3'b010;
        step("lw_fetch", v_fetch(2'b00, 1'b1));
        step("lw_decode", v_decode(2'b00));
        step("lw_memadr", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0));
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw_memread_wait", v(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
        MemReady = 1'b1;
        step("lw_memread", v(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
        step("lw_memwb", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0));
        exp_cnt++;

        // beq taken, bne not taken, both with Zero=1
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
        step("beq_fetch", v_fetch(2'b10, 1'b1));
        step("beq_decode", v_decode(2'b10));
        step("beq_branch", v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0));
        exp_cnt++;
        funct3 = 3'b001;
        step("bne_fetch", v_fetch(2'b10, 1'b1));
        step("bne_decode", v_decode(2'b10));
        step("bne_branch", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0));
        exp_cnt++;
        Zero = 1'b0;

        // jal
        op = 7'b1101111; funct3 = 3'b000;
        step("jal_fetch", v_fetch(2'b11, 1'b1));
        step("jal_decode", v_decode(2'b11));
        step("jal_jal", v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0));
        step("jal_aluwb", v_aluwb(2'b11));
        exp_cnt++;

        // sw with a stalled fetch and a stalled write
        op = 7'b0100011; funct3 = 3'b010; MemReady = 1'b0;
        step("sw_fetch_wait", v_fetch(2'b01, 1'b0));
        MemReady = 1'b1;
        step("sw_fetch", v_fetch(2'b01, 1'b1));
        step("sw_decode", v_decode(2'b01));
        step("sw_memadr", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0));
        MemReady = 1'b0;
        step("sw_memwrite_wait", v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0));
        MemReady = 1'b1;
        step("sw_memwrite", v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0));
        exp_cnt++;

        // addi with funct7_5=1 must still add
        op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
        step("addi_fetch", v_fetch(2'b00, 1'b1));
        step("addi_decode", v_decode(2'b00));
        step("addi_execi", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0));
        step("addi_aluwb", v_aluwb(2'b00));
        exp_cnt++;

        // R-type and
        op = 7'b0110011; funct3 = 3'b111; funct7_5 = 1'b0;
        step("and_fetch", v_fetch(2'b00, 1'b1));
        step("and_decode", v_decode(2'b00));
        step("and_execr", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0));
        step("and_aluwb", v_aluwb(2'b00));
        exp_cnt++;

        // R-type slt
        funct3 = 3'b010;
        step("slt_fetch", v_fetch(2'b00, 1'b1));
        step("slt_decode", v_decode(2'b00));
        step("slt_execr", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 1'b0, 1'b0));
        step("slt_aluwb", v_aluwb(2'b00));
        exp_cnt++;

        // ori
        op = 7'b0010011; funct3 = 3'b110;
        step("ori_fetch", v_fetch(2'b00, 1'b1));
        step("ori_decode", v_decode(2'b00));
        step("ori_execi", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00, 1'b0, 1'b0));
        step("ori_aluwb", v_aluwb(2'b00));
        exp_cnt++;

        // Unsupported opcode traps and holds; reset clears it asynchronously
        op = 7'b0110111; funct3 = 3'b000;
        step("ill_fetch", v_fetch(2'b00, 1'b1));
        step("ill_decode", v_decode(2'b00));
        for (int i = 0; i < 10; i++)
            step("ill_trap", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1));
        #2;
        RST = 1'b1;
        exp_cnt = 32'd0;
        check_async("ill_async_rst", v_rst(2'b00));
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset asserted in the middle of a stalled store
        op = 7'b0100011; funct3 = 3'b010;
        step("sw2_fetch", v_fetch(2'b01, 1'b1));
        step("sw2_decode", v_decode(2'b01));
        step("sw2_memadr", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0));
        MemReady = 1'b0;
        step("sw2_memwrite_wait", v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0));
        #2;
        RST = 1'b1;
        check_async("sw2_async_rst", v_rst(2'b01));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        MemReady = 1'b1;
        step("post_rst_fetch", v_fetch(2'b01, 1'b1));
        step("post_rst_decode", v_decode(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_v_mc_control.md
Name: risc_v_mc_control

Overview:
Multicycle control unit for the next-generation RISC-V core. It replaces the combinational single-cycle controller with a Moore FSM that sequences a shared instruction/data memory and a single ALU across several cycles per instruction. A MemReady handshake stretches memory states. The unit flags unsupported instructions and counts retired instructions.

Parameters:
OP_WIDTH, 7, opcode width
FUNCT3_WIDTH, 3, funct3 width
ALU_CTRL_WIDTH, 3, ALUControl width
IMM_SRC_WIDTH, 2, ImmSrc width
CNT_WIDTH, 32, retired-instruction counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
op  in  OP_WIDTH  Instr[6:0] from the instruction register
funct3  in  FUNCT3_WIDTH  Instr[14:12]
funct7_5  in  1  Instr[30]
Zero  in  1  ALU zero flag
MemReady  in  1  memory access complete this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register and OldPC enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1 register
ALUSrcB  out  2  00 = RD2 register, 01 = ImmExt, 10 = constant 4
ALUControl  out  ALU_CTRL_WIDTH  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  IMM_SRC_WIDTH  00 I, 01 S, 10 B, 11 J
RegWrite  out  1  register file write enable
Illegal  out  1  unsupported instruction trapped
InstrRetired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to FETCH; InstrRetired = 0; Illegal = 0.
  - While RST is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Reset mid-instruction abandons that instruction with no further writes.
- Supported opcodes:
  - 0000011 lw, funct3 010 only
  - 0100011 sw, funct3 010 only
  - 0110011 R-type
  - 0010011 I-ALU
  - 1101111 jal
  - 1100011 branch, funct3 000 (beq) or 001 (bne)
  - R-type and I-ALU accept funct3 000, 010, 110, 111.
  - Anything else is illegal.
- ImmSrc: combinational from op, independent of state. lw/I-ALU = 00, sw = 01, branch = 10, jal = 11, otherwise 00.
- ALUOp (internal):
  - ALUOp = 00 gives add; ALUOp = 01 gives sub.
  - ALUOp = 10 decodes funct3: 000 gives add, or sub when funct7_5 & op[5]; 010 gives slt; 110 gives or; 111 gives and.
- Signals not listed for a state are 0.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite = PCWrite = MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
    - lw/sw go to MEMADR.
    - R-type goes to EXECR.
    - I-ALU goes to EXECI.
    - jal goes to JAL.
    - branch goes to BRANCH.
    - illegal goes to TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw goes to MEMREAD; sw goes to MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Holds until MemReady, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then goes to FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. MemWrite stays asserted and the state holds until MemReady; then goes to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then goes to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then goes to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then goes to ALUWB (writes OldPC+4).
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero XOR funct3[0]. Then goes to FETCH.
  - TRAP: Illegal=1, all enables 0. Holds until reset.
- CPI (MemReady tied 1): lw 5, sw 4, R/I 4, jal 4, branch 3.
- InstrRetired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^CNT_WIDTH.
  - Never increments in TRAP.
- Invalid state encoding recovers to FETCH on the next edge.

Test Plan:
- Reset release, MemReady=1, op=0110011, funct3=000, funct7_5=1 -> states FETCH, DECODE, EXECR, ALUWB. ALUControl=001 in EXECR; RegWrite=1 only in ALUWB; InstrRetired=1 after 4 cycles.
- lw with MemReady low for 3 cycles in MEMREAD -> state holds 3 extra cycles with AdrSrc=1, then MEMWB asserts RegWrite and ResultSrc=01. Total 8 cycles.
- beq with Zero=1 -> PCWrite=1 in BRANCH; bne with Zero=1 -> PCWrite=0. Both return to FETCH after 3 cycles.
- jal -> ImmSrc=11. JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10; ALUWB follows with RegWrite=1.
- op=0110111 (unsupported) -> TRAP after DECODE; Illegal=1 held for 10 cycles; InstrRetired unchanged. RST clears Illegal immediately, asynchronously.
- Reset asserted mid-MEMWRITE -> MemWrite drops in the same cycle; after release the state is FETCH and InstrRetired=0. Counter wrap checked with CNT_WIDTH=2 after 4 retirements -> 0.
